// File: rtl/swisv_pkg.sv
// rtl/swisv_pkg.sv - shared SWIS-V core constants and fetch-stage types
package swisv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order {pc, instr} queue between fetch and decode
module fetch_fifo
    import swisv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  fetch_entry_t           i_wdata,
    input  logic                   i_pop,
    output logic                   o_valid,
    output fetch_entry_t           o_rdata,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     entries_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = i_pop && (count_q != '0);
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_push = i_push && ((count_q != FULL_CNT) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push && !i_flush) begin
                entries_q[wr_ptr_q] <= i_wdata;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_valid = (count_q != '0);
    assign o_rdata = entries_q[rd_ptr_q];
    assign o_count = count_q;

    push_while_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && !i_flush && !do_pop && (count_q == FULL_CNT)));

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - SWIS-V fetch stage: PC, imem request issue, in-order queue to decode
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect halts fetch and raises o_fetch_err.
module instr_fetch
    import swisv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_VECTOR,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_rvalid,
    input  logic [ILEN-1:0] i_imem_rdata,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [ILEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_fetch_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_LIM = OCC_W'(FIFO_DEPTH);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] shadow_pc_q;
    logic            inflight_q;
    logic            discard_q;
    logic            fetch_err_q, fetch_err_d;

    logic            redirect_act;
    logic            misaligned;
    logic [XLEN-1:0] redirect_tgt;
    logic            req;
    logic            pop;
    logic            push;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] fifo_count;
    logic            fifo_valid;
    fetch_entry_t    fifo_wdata;
    fetch_entry_t    fifo_head;

    assign redirect_act = i_redirect && (state_q == RUN);
    assign redirect_tgt = word_align(i_redirect_pc);

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned = redirect_act && (i_redirect_pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Slots already committed (held + one response on the way) minus the one leaving now.
    assign pop       = fifo_valid && i_ready;
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign push      = i_imem_rvalid && !discard_q && (state_q == RUN) && !redirect_act;

    always_comb begin
        state_d     = state_q;
        req         = 1'b0;
        fetch_pc_d  = fetch_pc_q;
        fetch_err_d = fetch_err_q;
        unique case (state_q)
            RESET: begin
                state_d = RUN;
            end
            RUN: begin
                req = !i_redirect && (occupancy < DEPTH_LIM);
                if (redirect_act) begin
                    fetch_pc_d = redirect_tgt;
                end else if (req) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
                if (misaligned) begin
                    state_d     = HALT;
                    fetch_err_d = 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RESET;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= RESET;
            fetch_pc_q  <= RESET_PC;
            shadow_pc_q <= RESET_PC;
            inflight_q  <= 1'b0;
            discard_q   <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            if (req) begin
                shadow_pc_q <= fetch_pc_q;
            end
            inflight_q  <= req;
            discard_q   <= redirect_act;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fifo_wdata = '{pc: shadow_pc_q, instr: i_imem_rdata};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (redirect_act),
        .i_push  (push),
        .i_wdata (fifo_wdata),
        .i_pop   (pop && !redirect_act),
        .o_valid (fifo_valid),
        .o_rdata (fifo_head),
        .o_count (fifo_count)
    );

    assign o_imem_req  = req;
    assign o_imem_addr = fetch_pc_q;
    assign o_valid     = fifo_valid;
    assign o_instr     = fifo_head.instr;
    assign o_pc        = fifo_head.pc;
    assign o_fetch_err = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_w_n;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        req, valid, err;
    logic        rvalid = 1'b0;
    logic [31:0] addr, instr, pc;
    logic [31:0] rdata = 32'h0;

    logic        w_req, w_valid, w_err;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_addr, w_instr, w_pc;
    logic [31:0] w_rdata = 32'h0;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          stall_reqs;
    logic [31:0] exp_pc = 32'h0;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h7FF00293;
            32'h0000_0004: return 32'h00F29313;
            default:       return a ^ 32'h5A5A_0013;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    instr_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
        .o_valid       (valid),
        .i_ready       (ready),
        .o_instr       (instr),
        .o_pc          (pc),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_fetch_err   (err)
    );

    instr_fetch #(
        .RESET_PC   (32'hFFFF_FFF8),
        .FIFO_DEPTH (DEPTH)
    ) dut_wrap (
        .i_clk         (clk),
        .i_rst_n       (rst_w_n),
        .o_imem_req    (w_req),
        .o_imem_addr   (w_addr),
        .i_imem_rvalid (w_rvalid),
        .i_imem_rdata  (w_rdata),
        .o_valid       (w_valid),
        .i_ready       (1'b1),
        .o_instr       (w_instr),
        .o_pc          (w_pc),
        .i_redirect    (1'b0),
        .i_redirect_pc (32'h0),
        .o_fetch_err   (w_err)
    );

    // One-cycle instruction memory shared in behaviour by both instances.
    always @(posedge clk) begin
        rvalid   <= req;
        rdata    <= instr_of(addr);
        w_rvalid <= w_req;
        w_rdata  <= instr_of(w_addr);
    end

    // Decode-side scoreboard: the head must always be the next expected in-order word.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc = 32'h0;
        end else if (redirect) begin
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (valid) begin
            check("head_pc", pc, exp_pc);
            check("head_instr", instr, instr_of(exp_pc));
            if (ready) begin
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        rst_w_n     = 1'b0;
        ready       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        #17;
        check("rst_req", 32'(req), 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_w_addr", w_addr, 32'hFFFF_FFF8);

        @(negedge clk);
        #1;
        rst_n   = 1'b1;
        rst_w_n = 1'b1;

        cyc();  // cycle 1
        check("c1_req", 32'(req), 32'h1);
        check("c1_addr", addr, 32'h0);
        check("c1_valid", 32'(valid), 32'h0);
        check("w_c1_addr", w_addr, 32'hFFFF_FFF8);
        cyc();  // cycle 2
        check("c2_addr", addr, 32'h4);
        check("c2_valid", 32'(valid), 32'h0);
        check("w_c2_addr", w_addr, 32'hFFFF_FFFC);
        cyc();  // cycle 3
        check("c3_valid", 32'(valid), 32'h1);
        check("c3_pc", pc, 32'h0);
        check("c3_instr", instr, 32'h7FF00293);
        check("w_c3_addr", w_addr, 32'h0);
        check("w_c3_pc", w_pc, 32'hFFFF_FFF8);
        cyc();  // cycle 4
        check("c4_pc", pc, 32'h4);
        check("c4_instr", instr, 32'h00F29313);
        check("w_c4_addr", w_addr, 32'h4);
        check("w_c4_pc", w_pc, 32'hFFFF_FFFC);
        cyc();  // cycle 5
        check("w_c5_pc", w_pc, 32'h0);
        cyc();
        cyc();  // cycle 7: stall begins

        ready      = 1'b0;
        stall_reqs = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            stall_reqs += int'(req);
            cyc();
        end
        check("stall_reqs", 32'(stall_reqs), 32'h0);
        check("stall_req_off", 32'(req), 32'h0);
        check("stall_held", addr - pc, 32'(DEPTH * 4));
        ready = 1'b1;
        #1;
        check("release_req", 32'(req), 32'h1);
        check("release_valid", 32'(valid), 32'h1);
        cyc();
        cyc();
        cyc();  // cycle 16: redirect with queue committed and a response arriving

        check("t3_pre_rvalid", 32'(rvalid), 32'h1);
        ready       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        #1;
        check("t3_redir_req", 32'(req), 32'h0);
        cyc();
        redirect = 1'b0;
        ready    = 1'b1;
        #1;
        check("t3_n1_valid", 32'(valid), 32'h0);
        check("t3_n1_req", 32'(req), 32'h1);
        check("t3_n1_addr", addr, 32'h100);
        cyc();
        check("t3_n2_valid", 32'(valid), 32'h0);
        cyc();
        check("t3_n3_valid", 32'(valid), 32'h1);
        check("t3_n3_pc", pc, 32'h100);
        cyc();
        cyc();  // cycle 21: redirect coincides with pop and push

        check("t4_pre_valid", 32'(valid), 32'h1);
        check("t4_pre_rvalid", 32'(rvalid), 32'h1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        cyc();
        redirect = 1'b0;
        #1;
        check("t4_n1_valid", 32'(valid), 32'h0);
        cyc();
        check("t4_n2_valid", 32'(valid), 32'h0);
        cyc();
        check("t4_n3_valid", 32'(valid), 32'h1);
        check("t4_n3_pc", pc, 32'h200);
        cyc();
        cyc();  // cycle 26: misaligned redirect

        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        cyc();
        redirect = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        check("t5_err", 32'(err), 32'h1);
        check("t5_req", 32'(req), 32'h0);
        check("t5_valid", 32'(valid), 32'h0);
        cyc();
        cyc();
        check("t5_halt_req", 32'(req), 32'h0);
        check("t5_halt_valid", 32'(valid), 32'h0);
        check("t5_halt_err", 32'(err), 32'h1);
`else
        check("t5_err", 32'(err), 32'h0);
        check("t5_req", 32'(req), 32'h1);
        check("t5_addr", addr, 32'h100);
        cyc();
        cyc();
        check("t5_valid", 32'(valid), 32'h1);
        check("t5_pc", pc, 32'h100);
`endif
        cyc();

        check("w_pre_rst_valid", 32'(w_valid), 32'h1);
        rst_w_n = 1'b0;
        #1;
        check("w_mid_rst_req", 32'(w_req), 32'h0);
        check("w_mid_rst_addr", w_addr, 32'hFFFF_FFF8);
        check("w_mid_rst_valid", 32'(w_valid), 32'h0);
        check("w_mid_rst_instr", w_instr, 32'h0);
        check("w_mid_rst_pc", w_pc, 32'h0);
        check("w_mid_rst_err", 32'(w_err), 32'h0);

        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(req), 32'h0);
        check("mid_rst_addr", addr, 32'h0);
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_instr", instr, 32'h0);
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_err", 32'(err), 32'h0);

        @(negedge clk);
        #1;
        rst_n   = 1'b1;
        rst_w_n = 1'b1;
        cyc();
        check("re_c1_req", 32'(req), 32'h1);
        check("re_c1_addr", addr, 32'h0);
        cyc();
        check("re_c2_valid", 32'(valid), 32'h0);
        cyc();
        check("re_c3_valid", 32'(valid), 32'h1);
        check("re_c3_pc", pc, 32'h0);
        check("re_c3_instr", instr, 32'h7FF00293);
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
